// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer driven by the four-phase timing
// generator. One t1..t4 round is one machine cycle:
//   t1 fetch udata into uir, t2 drive ctrl, t3 select the next address,
//   t4 commit upc and clear ctrl.
// Build option SINGLE_STEP_EN adds a step input and a STEP state that runs
// exactly one machine cycle out of HALT.
//
// state | meaning
// RUN   | executing microinstructions, one per t1..t4 round
// HALT  | upc/uir/unext/ctrl frozen, waiting for run_req (or step)
// STEP  | one machine cycle with RUN rules, then back to HALT (SINGLE_STEP_EN)
module micro_sequencer #(
  parameter int AW         = 6,
  parameter int CW         = 16,
  parameter int OPW        = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              t1,
  input  logic              t2,
  input  logic              t3,
  input  logic              t4,
  input  logic [CW+AW+2:0]  udata,
  input  logic [OPW-1:0]    ir_op,
  input  logic              cond,
  input  logic              halt_req,
  input  logic              run_req,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [AW-1:0]     uaddr,
  output logic [CW-1:0]     ctrl,
  output logic              halted,
  output logic              phase_err
);

  localparam int UW = CW + AW + 3;

`ifdef SINGLE_STEP_EN
  typedef enum logic [1:0] {S_RUN = 2'd0, S_HALT = 2'd1, S_STEP = 2'd2} state_t;
`else
  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;
`endif

  state_t          state, state_nxt;
  logic [AW-1:0]   upc, unext, addr_sel;
  logic [UW-1:0]   uir;
  logic [1:0]      exp_ph;
  logic [3:0]      phase_v, exp_vec;
  logic            ph_ok, ph_bad, active;

  logic            uir_hlt;
  logic [1:0]      uir_seq;
  logic [AW-1:0]   uir_next;
  logic [CW-1:0]   uir_ctrl;

  assign uir_hlt  = uir[UW-1];
  assign uir_seq  = uir[UW-2:UW-3];
  assign uir_next = uir[CW+AW-1:CW];
  assign uir_ctrl = uir[CW-1:0];

  assign uaddr = upc;

  // Phase qualification: exactly the expected one-hot pulse is accepted.
  // Since exp_vec is one-hot, equality also rules out multiple pulses.
  assign phase_v = {t4, t3, t2, t1};
  assign exp_vec = 4'b0001 << exp_ph;
  assign ph_ok   = (phase_v != 4'b0000) && (phase_v == exp_vec);
  assign ph_bad  = (phase_v != 4'b0000) && (phase_v != exp_vec);
  assign active  = (state != S_HALT);

  // Next micro-address selection from the sequencing field.
  always_comb begin
    addr_sel = upc + AW'(1);
    case (uir_seq)
      2'b00: addr_sel = upc + AW'(1);
      2'b01: addr_sel = uir_next;
      2'b10: addr_sel = {ir_op, {(AW-OPW){1'b0}}};
      2'b11: addr_sel = cond ? uir_next : upc + AW'(1);
      default: addr_sel = upc + AW'(1);
    endcase
  end

  // Next-state logic: transitions only happen on an accepted phase-4 edge.
  always_comb begin
    state_nxt = state;
    if (ph_ok && t4) begin
      case (state)
        S_RUN: begin
          if (uir_hlt || halt_req)
            state_nxt = S_HALT;
        end
        S_HALT: begin
          if (halt_req)
            state_nxt = S_HALT;
          else if (run_req)
            state_nxt = S_RUN;
`ifdef SINGLE_STEP_EN
          else if (step)
            state_nxt = S_STEP;
`endif
        end
`ifdef SINGLE_STEP_EN
        S_STEP: state_nxt = S_HALT;
`endif
        default: state_nxt = S_HALT;
      endcase
    end
  end

  // State register; halted is registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_RUN;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == S_HALT);
    end
  end

  // Phase tracker and sticky protocol error; an illegal pulse resyncs to t1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_ph    <= 2'd0;
      phase_err <= 1'b0;
    end else if (ph_bad) begin
      exp_ph    <= 2'd0;
      phase_err <= 1'b1;
    end else if (ph_ok) begin
      exp_ph    <= exp_ph + 2'd1;
    end
  end

  // Microinstruction datapath: fetch, drive, select, commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc   <= AW'(RESET_ADDR);
      unext <= AW'(RESET_ADDR);
      uir   <= '0;
      ctrl  <= '0;
    end else if (ph_ok && active) begin
      if (t1) uir   <= udata;
      if (t2) ctrl  <= uir_ctrl;
      if (t3) unext <= addr_sel;
      if (t4) begin
        upc  <= unext;
        ctrl <= '0;
      end
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer. The control store is a
// bench-owned array read combinationally at uaddr.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        t1 = 1'b0, t2 = 1'b0, t3 = 1'b0, t4 = 1'b0;
  logic [24:0] udata;
  logic [3:0]  ir_op = 4'h0;
  logic        cond = 1'b0;
  logic        halt_req = 1'b0;
  logic        run_req = 1'b0;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic [5:0]  uaddr;
  logic [15:0] ctrl;
  logic        halted;
  logic        phase_err;

  logic [24:0] rom [64];
  int          n_checks = 0;
  int          n_fail = 0;

  assign udata = rom[uaddr];

  micro_sequencer #(.AW(6), .CW(16), .OPW(4), .RESET_ADDR(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .t1        (t1),
    .t2        (t2),
    .t3        (t3),
    .t4        (t4),
    .udata     (udata),
    .ir_op     (ir_op),
    .cond      (cond),
    .halt_req  (halt_req),
    .run_req   (run_req),
`ifdef SINGLE_STEP_EN
    .step      (step),
`endif
    .uaddr     (uaddr),
    .ctrl      (ctrl),
    .halted    (halted),
    .phase_err (phase_err)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] uword(input logic h, input logic [1:0] s,
                                        input logic [5:0] n, input logic [15:0] c);
    return {h, s, n, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 64; i++) rom[i] = uword(1'b0, 2'b00, 6'h00, 16'hA5A5);
  endtask

  // Called at a falling edge; leaves the bench at a falling edge.
  task automatic do_reset();
    {t4, t3, t2, t1} = 4'b0000;
    halt_req = 1'b0;
    run_req  = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    @(negedge clk);
  endtask

  // Drive one pulse pattern for exactly one clock.
  task automatic pulse(input logic [3:0] ph);
    {t4, t3, t2, t1} = ph;
    @(negedge clk);
    {t4, t3, t2, t1} = 4'b0000;
  endtask

  // One full machine cycle with ctrl window and resulting address checks.
  task automatic round(input string tag, input logic [15:0] exp_ctrl, input logic [5:0] exp_addr);
    pulse(4'b0001);
    check({tag, " ctrl@t1"}, 32'(ctrl), 32'h0);
    pulse(4'b0010);
    check({tag, " ctrl@t2"}, 32'(ctrl), 32'(exp_ctrl));
    pulse(4'b0100);
    check({tag, " ctrl@t3"}, 32'(ctrl), 32'(exp_ctrl));
    pulse(4'b1000);
    check({tag, " ctrl@t4"}, 32'(ctrl), 32'h0);
    check({tag, " uaddr"}, 32'(uaddr), 32'(exp_addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_rom();
    @(negedge clk);
    do_reset();
    @(negedge clk);
    check("rst uaddr", 32'(uaddr), 32'h0);
    check("rst ctrl", 32'(ctrl), 32'h0);
    check("rst halted", 32'(halted), 32'h0);
    check("rst phase_err", 32'(phase_err), 32'h0);

    // Sequential fetch
    for (int i = 0; i < 4; i++) round("seq", 16'hA5A5, 6'(i + 1));

    // Opcode dispatch at addr 2, then conditional jumps
    do_reset();
    rom[2]    = uword(1'b0, 2'b10, 6'h00, 16'h1234);
    rom[6'h14] = uword(1'b0, 2'b11, 6'h30, 16'h0F0F);
    rom[6'h30] = uword(1'b0, 2'b01, 6'h05, 16'h3C3C);
    rom[5]    = uword(1'b0, 2'b11, 6'h30, 16'h7777);
    ir_op = 4'h5;
    round("disp0", 16'hA5A5, 6'h01);
    round("disp1", 16'hA5A5, 6'h02);
    round("disp", 16'h1234, 6'h14);
    cond = 1'b1;
    round("cond1", 16'h0F0F, 6'h30);
    round("jump", 16'h3C3C, 6'h05);
    cond = 1'b0;
    round("cond0", 16'h7777, 6'h06);

    // Halt bit at addr 3
    fill_rom();
    rom[3] = uword(1'b1, 2'b00, 6'h00, 16'hBEEF);
    rom[4] = uword(1'b0, 2'b01, 6'h22, 16'h5A5A);
    do_reset();
    for (int i = 0; i < 3; i++) round("pre", 16'hA5A5, 6'(i + 1));
    round("hlt", 16'hBEEF, 6'h04);
    check("hlt halted", 32'(halted), 32'h1);
    for (int i = 0; i < 3; i++) begin
      round("frozen", 16'h0000, 6'h04);
      check("frozen halted", 32'(halted), 32'h1);
    end
    halt_req = 1'b1;
    run_req  = 1'b1;
    round("prio", 16'h0000, 6'h04);
    check("prio halted", 32'(halted), 32'h1);
    halt_req = 1'b0;
    round("resume", 16'h0000, 6'h04);
    run_req  = 1'b0;
    check("resume halted", 32'(halted), 32'h0);
    round("refetch", 16'h5A5A, 6'h22);
    halt_req = 1'b1;
    round("hreq", 16'hA5A5, 6'h23);
    halt_req = 1'b0;
    check("hreq halted", 32'(halted), 32'h1);

    // Phase protocol: skipped t2
    fill_rom();
    rom[0] = uword(1'b0, 2'b00, 6'h00, 16'h1111);
    do_reset();
    pulse(4'b0001);
    pulse(4'b0100);
    check("skip phase_err", 32'(phase_err), 32'h1);
    check("skip ctrl", 32'(ctrl), 32'h0);
    check("skip uaddr", 32'(uaddr), 32'h0);
    round("resync", 16'h1111, 6'h01);
    check("sticky phase_err", 32'(phase_err), 32'h1);

    // Multi-hot pulse
    do_reset();
    check("clr phase_err", 32'(phase_err), 32'h0);
    pulse(4'b0011);
    check("multi phase_err", 32'(phase_err), 32'h1);
    check("multi ctrl", 32'(ctrl), 32'h0);

    // Reset mid-cycle, then t2 first
    do_reset();
    pulse(4'b0001);
    pulse(4'b0010);
    check("mid ctrl", 32'(ctrl), 32'h1111);
    do_reset();
    check("mid rst ctrl", 32'(ctrl), 32'h0);
    pulse(4'b0010);
    check("mid t2 phase_err", 32'(phase_err), 32'h1);
    check("mid t2 ctrl", 32'(ctrl), 32'h0);

    // Address wrap
    fill_rom();
    rom[0]     = uword(1'b0, 2'b01, 6'h3F, 16'h2222);
    rom[6'h3F] = uword(1'b0, 2'b00, 6'h00, 16'h3333);
    do_reset();
    round("to3f", 16'h2222, 6'h3F);
    round("wrap", 16'h3333, 6'h00);

`ifdef SINGLE_STEP_EN
    fill_rom();
    do_reset();
    halt_req = 1'b1;
    round("st halt", 16'hA5A5, 6'h01);
    halt_req = 1'b0;
    check("st halted", 32'(halted), 32'h1);
    step = 1'b1;
    round("st enter", 16'h0000, 6'h01);
    step = 1'b0;
    check("st halted low", 32'(halted), 32'h0);
    round("st exec", 16'hA5A5, 6'h02);
    check("st rehalt", 32'(halted), 32'h1);
    round("st idle", 16'h0000, 6'h02);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
